// File: rtl/load_writeback_if.sv
// Load/writeback bundle: request channel, split memory read channel, and
// the register-file write port plus status flags.
interface load_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);

  // Request channel
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_rd;
  logic [31:0]           req_addr;
  logic [2:0]            req_funct3;

  // Memory read address channel
  logic                  mem_arvalid;
  logic                  mem_arready;
  logic [31:0]           mem_araddr;

  // Memory read data channel
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerr;

  // Register-file write port and status
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  busy;
  logic                  load_err;

  // Block side
  modport slave (
    input  req_valid, req_rd, req_addr, req_funct3,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rerr,
    output req_ready, mem_arvalid, mem_araddr, mem_rready,
    output rf_wen, rf_waddr, rf_wdata, busy, load_err
  );

  // Environment side (issuer of loads and memory model)
  modport master (
    output req_valid, req_rd, req_addr, req_funct3,
    output mem_arready, mem_rvalid, mem_rdata, mem_rerr,
    input  req_ready, mem_arvalid, mem_araddr, mem_rready,
    input  rf_wen, rf_waddr, rf_wdata, busy, load_err
  );

endinterface

// File: rtl/load_writeback.sv
// Single-outstanding RV32I load unit: checks the request, issues one
// word-aligned memory read, then aligns/extends the returned word and
// writes it to the register file. Illegal or failed loads pulse load_err.
module load_writeback #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_writeback_if.slave  bus
);

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {StIdle, StAr, StR, StWb} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [31:0]           araddr_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic                  req_legal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;

  // Legality of the incoming request: known funct3 and natural alignment.
  always_comb begin
    req_legal = 1'b0;
    case (bus.req_funct3)
      F3Lb, F3Lbu: req_legal = 1'b1;
      F3Lh, F3Lhu: req_legal = ~bus.req_addr[0];
      F3Lw:        req_legal = (bus.req_addr[1:0] == 2'b00);
      default:     req_legal = 1'b0;
    endcase
  end

  // Lane selection and sign/zero extension of the returned word.
  always_comb begin
    byte_sel  = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_sel  = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_data = bus.mem_rdata;
    case (funct3_q)
      F3Lb:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3Lh:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3Lbu:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3Lhu:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Control FSM with registered write port, error pulse and read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rd_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      araddr_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // Single-cycle pulses by default
      wen_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            if (req_legal) begin
              rd_q     <= bus.req_rd;
              funct3_q <= bus.req_funct3;
              off_q    <= bus.req_addr[1:0];
              araddr_q <= {bus.req_addr[31:2], 2'b00};
              state_q  <= StAr;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StAr: begin
          if (bus.mem_arready) begin
            state_q <= StR;
          end
        end
        StR: begin
          if (bus.mem_rvalid) begin
            if (bus.mem_rerr) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              // x0 is never written, but the access itself still completes
              wen_q   <= (rd_q != '0);
              waddr_q <= rd_q;
              wdata_q <= load_data;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.mem_arvalid = (state_q == StAr);
  assign bus.mem_araddr  = araddr_q;
  assign bus.mem_rready  = (state_q == StR);
  assign bus.rf_wen      = wen_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.load_err    = err_q;

endmodule

// File: tb/tb_load_writeback.sv
// Bench for load_writeback: directed vector table, randomized loads against
// an arithmetic reference model, and an asynchronous-reset sequence.
module tb_load_writeback;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  load_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  load_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Last value written to the register file, when known
  logic [AW-1:0] exp_waddr;
  logic [31:0]   exp_wdata;
  bit            wb_known;

  typedef struct {
    logic [AW-1:0] rd;
    logic [31:0]   addr;
    logic [2:0]    f3;
    logic [31:0]   rdata;
    bit            rerr;
    int            ar_dly;
    int            r_dly;
    bit            poke;
    bit            legal;
    logic [31:0]   data;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: {legal, loaded value} from the RV32I load rules.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned     nbytes;
    longint unsigned val;
    longint unsigned lim;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    return 33'd0;
    endcase
    if ((addr % nbytes) != 0) return 33'd0;
    lim = 64'd1 << (8 * nbytes);
    val = ({32'd0, rdata} >> (8 * (addr % 4))) % lim;
    if (f3 < 3'd4 && nbytes < 4 && val >= lim / 2) val = val + 64'h1_0000_0000 - lim;
    return {1'b1, val[31:0]};
  endfunction

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_rd      = '0;
    bus.req_addr    = '0;
    bus.req_funct3  = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rerr    = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    if (wb_known) begin
      check({tag, " waddr hold"}, 32'(bus.rf_waddr), 32'(exp_waddr));
      check({tag, " wdata hold"}, bus.rf_wdata, exp_wdata);
    end
  endtask

  // One load from an idle DUT, starting and ending at a falling edge.
  task automatic run_load(input string tag, input logic [AW-1:0] rd, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] rdata, input bit rerr,
                          input int ar_dly, input int r_dly, input bit poke,
                          input bit legal, input logic [31:0] data);
    check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_rd     = rd;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!legal) begin
      check({tag, " reject err"}, 32'(bus.load_err), 32'd1);
      check({tag, " reject arvalid"}, 32'(bus.mem_arvalid), 32'd0);
      check({tag, " reject busy"}, 32'(bus.busy), 32'd0);
      check({tag, " reject wen"}, 32'(bus.rf_wen), 32'd0);
      @(negedge clk);
      check({tag, " reject err clr"}, 32'(bus.load_err), 32'd0);
      check({tag, " reject arvalid2"}, 32'(bus.mem_arvalid), 32'd0);
      check_hold(tag);
      return;
    end
    check({tag, " accept err"}, 32'(bus.load_err), 32'd0);
    check({tag, " accept busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i <= ar_dly; i++) begin
      check({tag, " ar arvalid"}, 32'(bus.mem_arvalid), 32'd1);
      check({tag, " ar araddr"}, bus.mem_araddr, {addr[31:2], 2'b00});
      check({tag, " ar req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, " ar wen"}, 32'(bus.rf_wen), 32'd0);
      if (poke) begin
        bus.req_valid  = 1'b1;
        bus.req_rd     = AW'($urandom);
        bus.req_addr   = $urandom;
        bus.req_funct3 = 3'($urandom);
      end
      bus.mem_arready = (i == ar_dly);
      @(negedge clk);
    end
    bus.mem_arready = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      check({tag, " r rready"}, 32'(bus.mem_rready), 32'd1);
      check({tag, " r arvalid"}, 32'(bus.mem_arvalid), 32'd0);
      check({tag, " r req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, " r wen"}, 32'(bus.rf_wen), 32'd0);
      bus.req_valid  = poke;
      bus.mem_rvalid = (i == r_dly);
      bus.mem_rdata  = (i == r_dly) ? rdata : $urandom;
      bus.mem_rerr   = (i == r_dly) ? rerr : 1'($urandom);
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rerr   = 1'b0;
    if (rerr) begin
      check({tag, " rerr err"}, 32'(bus.load_err), 32'd1);
      check({tag, " rerr wen"}, 32'(bus.rf_wen), 32'd0);
      check({tag, " rerr busy"}, 32'(bus.busy), 32'd0);
      check_hold(tag);
      @(negedge clk);
      check({tag, " rerr err clr"}, 32'(bus.load_err), 32'd0);
      return;
    end
    check({tag, " wb wen"}, 32'(bus.rf_wen), 32'(rd != '0));
    check({tag, " wb busy"}, 32'(bus.busy), 32'd1);
    check({tag, " wb err"}, 32'(bus.load_err), 32'd0);
    check({tag, " wb rready"}, 32'(bus.mem_rready), 32'd0);
    if (rd != '0) begin
      check({tag, " wb waddr"}, 32'(bus.rf_waddr), 32'(rd));
      check({tag, " wb wdata"}, bus.rf_wdata, data);
      exp_waddr = rd;
      exp_wdata = data;
      wb_known  = 1'b1;
    end else begin
      wb_known = 1'b0;
    end
    @(negedge clk);
    check({tag, " post wen"}, 32'(bus.rf_wen), 32'd0);
    check({tag, " post busy"}, 32'(bus.busy), 32'd0);
    check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    check_hold(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " arvalid"}, 32'(bus.mem_arvalid), 32'd0);
    check({tag, " rready"}, 32'(bus.mem_rready), 32'd0);
    check({tag, " wen"}, 32'(bus.rf_wen), 32'd0);
    check({tag, " err"}, 32'(bus.load_err), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " araddr"}, bus.mem_araddr, 32'd0);
    check({tag, " waddr"}, 32'(bus.rf_waddr), 32'd0);
    check({tag, " wdata"}, bus.rf_wdata, 32'd0);
  endtask

  initial begin
    logic [32:0]   r;
    logic [AW-1:0] rd;
    logic [31:0]   addr;
    logic [31:0]   rdata;
    logic [2:0]    f3;
    bit            rerr;

    //           rd  addr          f3     rdata         rerr ar r poke legal data
    vecs[0]  = '{5,  32'h8000_0004, 3'b010, 32'h1234_5678, 0, 0, 0, 0, 1, 32'h1234_5678};
    vecs[1]  = '{7,  32'h8000_0003, 3'b000, 32'h80FF_FFFF, 0, 0, 0, 0, 1, 32'hFFFF_FF80};
    vecs[2]  = '{8,  32'h8000_0003, 3'b100, 32'h80FF_FFFF, 0, 0, 0, 0, 1, 32'h0000_0080};
    vecs[3]  = '{9,  32'h8000_0002, 3'b101, 32'hBEEF_0000, 0, 0, 0, 0, 1, 32'h0000_BEEF};
    vecs[4]  = '{3,  32'h8000_0001, 3'b001, 32'h0,         0, 0, 0, 0, 0, 32'h0};
    vecs[5]  = '{3,  32'h8000_0000, 3'b011, 32'h0,         0, 0, 0, 0, 0, 32'h0};
    vecs[6]  = '{10, 32'h8000_0010, 3'b010, 32'hCAFE_F00D, 0, 3, 2, 1, 1, 32'hCAFE_F00D};
    vecs[7]  = '{11, 32'h8000_0020, 3'b010, 32'h5555_AAAA, 1, 0, 0, 0, 1, 32'h0};
    vecs[8]  = '{0,  32'h8000_0024, 3'b010, 32'h1111_2222, 0, 0, 0, 0, 1, 32'h0};
    vecs[9]  = '{12, 32'h0000_0006, 3'b001, 32'h8001_7FFF, 0, 1, 1, 0, 1, 32'hFFFF_8001};
    vecs[10] = '{13, 32'h0000_0001, 3'b000, 32'h0000_7F00, 0, 0, 0, 0, 1, 32'h0000_007F};
    vecs[11] = '{14, 32'h0000_0002, 3'b010, 32'h0,         0, 0, 0, 0, 0, 32'h0};
    vecs[12] = '{15, 32'h0000_0000, 3'b110, 32'h0,         0, 0, 0, 0, 0, 32'h0};
    vecs[13] = '{16, 32'h0000_0003, 3'b101, 32'h0,         0, 0, 0, 0, 0, 32'h0};

    idle_inputs();
    exp_waddr = '0;
    exp_wdata = '0;
    wb_known  = 1'b1;

    // Reset values while held and right after release
    repeat (2) @(negedge clk);
    check_reset_values("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset req_ready", 32'(bus.req_ready), 32'd1);
    check_reset_values("post reset");

    // Stray read data with nothing outstanding is not accepted
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("stray rready", 32'(bus.mem_rready), 32'd0);
    check("stray busy", 32'(bus.busy), 32'd0);
    check("stray wen", 32'(bus.rf_wen), 32'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_load($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].f3, vecs[i].rdata,
               vecs[i].rerr, vecs[i].ar_dly, vecs[i].r_dly, vecs[i].poke, vecs[i].legal,
               vecs[i].data);
    end

    // Randomized loads against the reference model
    for (int n = 0; n < 150; n++) begin
      rd    = AW'($urandom);
      f3    = 3'($urandom);
      addr  = $urandom;
      rdata = $urandom;
      rerr  = ($urandom_range(0, 7) == 0);
      r     = ref_load(f3, addr, rdata);
      run_load($sformatf("rnd%0d", n), rd, addr, f3, rdata, rerr, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), r[32], r[31:0]);
    end

    // Asynchronous reset while waiting for read data
    bus.req_valid  = 1'b1;
    bus.req_rd     = 5'd14;
    bus.req_addr   = 32'h0000_0040;
    bus.req_funct3 = 3'b010;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.mem_arready = 1'b1;
    @(negedge clk);
    bus.mem_arready = 1'b0;
    check("midR rready", 32'(bus.mem_rready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after reset req_ready", 32'(bus.req_ready), 32'd1);
      check_reset_values("after reset");
    end
    bus.mem_rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
